// File: rtl/decode_queue_unit.sv
// decode_queue_unit: buffered RV32I(+M) decode stage between IF and the ID/EX register.
// Latency: 1 edge from input transfer to decoded slot when the queue is empty (bypass), else FIFO order.
// Backpressure: in_ready = (count < DEPTH); the output slot holds stable while out_ready is low.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   flush                    squash every buffered and presented instruction
//   in_valid/in_ready        upstream handshake carrying in_pc / in_instr
//   out_valid/out_ready      downstream handshake carrying out_pc / out_instr and the decoded controls
//   JalD..ImmType            decoded control bundle (zero / NOBRANCH / NOREGWRITE while out_valid=0)
//   MulDivD, MulDivOpD       M-extension op flag and its Fn3
//   IllegalD                 slot instruction is not a legal RV32I(+M) encoding
//   count                    FIFO occupancy, output slot excluded

module decode_queue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdat_i,
  output logic [W-1:0]     rdat_o,
  output logic [CNT_W-1:0] count_o
);
  // Generic FIFO; caller guarantees no push when full and no pop when empty.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) cnt_d = cnt_q + CNT_W'(1);
    else if (!push_i && pop_i) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdat_i;
        // DEPTH is a power of two, so natural pointer overflow wraps the ring.
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  assign rdat_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
endmodule

module decode_queue_unit #(
  parameter int PC_W     = 32,
  parameter int DEPTH    = 4,
  parameter int ENABLE_M = 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic             JalD,
  output logic             JalrD,
  output logic             LoadNpcD,
  output logic             MemToRegD,
  output logic             AluSrc1D,
  output logic [2:0]       RegWriteD,
  output logic [3:0]       MemWriteD,
  output logic [1:0]       RegReadD,
  output logic [2:0]       BranchTypeD,
  output logic [3:0]       AluContrlD,
  output logic [1:0]       AluSrc2D,
  output logic [2:0]       ImmType,
  output logic             MulDivD,
  output logic [2:0]       MulDivOpD,
  output logic             IllegalD,
  output logic [CNT_W-1:0] count
);
  // Opcodes
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_NIMM  = 7'b0110011;

  // Parameters.v encodings
  localparam logic [2:0] NOBRANCH = 3'd0, BEQ = 3'd1, BNE = 3'd2, BLT = 3'd3,
                         BLTU = 3'd4, BGE = 3'd5, BGEU = 3'd6;
  localparam logic [2:0] RTYPE = 3'd0, ITYPE = 3'd1, STYPE = 3'd2, BTYPE = 3'd3,
                         UTYPE = 3'd4, JTYPE = 3'd5;
  localparam logic [2:0] NOREGWRITE = 3'd0, LB = 3'd1, LH = 3'd2, LW = 3'd3,
                         LBU = 3'd4, LHU = 3'd5;
  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3,
                         ALU_SUB = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10;

  localparam int E_W = PC_W + 32;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       load_npc;
    logic       mem_to_reg;
    logic       alu_src1;
    logic [2:0] reg_write;
    logic [3:0] mem_write;
    logic [1:0] reg_read;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src2;
    logic [2:0] imm_type;
    logic       mul_div;
    logic [2:0] mul_div_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t      c;
    logic [6:0] op;
    logic [6:0] fn7;
    logic [2:0] fn3;
    logic [3:0] alu_fn3;
    c   = '0;
    op  = instr[6:0];
    fn3 = instr[14:12];
    fn7 = instr[31:25];
    case (fn3)
      3'b000:  alu_fn3 = ALU_ADD;
      3'b001:  alu_fn3 = ALU_SLL;
      3'b010:  alu_fn3 = ALU_SLT;
      3'b011:  alu_fn3 = ALU_SLTU;
      3'b100:  alu_fn3 = ALU_XOR;
      3'b101:  alu_fn3 = ALU_SRL;
      3'b110:  alu_fn3 = ALU_OR;
      default: alu_fn3 = ALU_AND;
    endcase
    c.alu_ctrl = ALU_ADD;
    case (op)
      OP_LUI: begin
        c.reg_write = LW;
        c.alu_ctrl  = ALU_LUI;
        c.alu_src2  = 2'b10;
        c.imm_type  = UTYPE;
      end
      OP_AUIPC: begin
        c.reg_write = LW;
        c.alu_src1  = 1'b1;
        c.alu_src2  = 2'b10;
        c.imm_type  = UTYPE;
      end
      OP_JAL: begin
        c.jal       = 1'b1;
        c.load_npc  = 1'b1;
        c.reg_write = LW;
        c.imm_type  = JTYPE;
      end
      OP_JALR: begin
        c.jalr      = 1'b1;
        c.load_npc  = 1'b1;
        c.reg_write = LW;
        c.alu_src2  = 2'b10;
        c.reg_read  = 2'b10;
        c.imm_type  = ITYPE;
        c.illegal   = (fn3 != 3'b000);
      end
      OP_LD: begin
        c.mem_to_reg = 1'b1;
        c.alu_src2   = 2'b10;
        c.reg_read   = 2'b10;
        c.imm_type   = ITYPE;
        case (fn3)
          3'b000:  c.reg_write = LB;
          3'b001:  c.reg_write = LH;
          3'b010:  c.reg_write = LW;
          3'b100:  c.reg_write = LBU;
          3'b101:  c.reg_write = LHU;
          default: c.illegal   = 1'b1;
        endcase
      end
      OP_ST: begin
        c.alu_src2 = 2'b10;
        c.reg_read = 2'b11;
        c.imm_type = STYPE;
        case (fn3)
          3'b000:  c.mem_write = 4'b0001;
          3'b001:  c.mem_write = 4'b0011;
          3'b010:  c.mem_write = 4'b1111;
          default: c.illegal   = 1'b1;
        endcase
      end
      OP_BR: begin
        c.reg_read = 2'b11;
        c.imm_type = BTYPE;
        case (fn3)
          3'b000:  c.branch_type = BEQ;
          3'b001:  c.branch_type = BNE;
          3'b100:  c.branch_type = BLT;
          3'b101:  c.branch_type = BGE;
          3'b110:  c.branch_type = BLTU;
          3'b111:  c.branch_type = BGEU;
          default: c.illegal     = 1'b1;
        endcase
      end
      OP_IMM: begin
        c.reg_write = LW;
        c.reg_read  = 2'b10;
        c.imm_type  = ITYPE;
        c.alu_ctrl  = alu_fn3;
        // Shift-immediates take the shamt field, everything else the full immediate.
        c.alu_src2  = (fn3 == 3'b001 || fn3 == 3'b101) ? 2'b01 : 2'b10;
        if (fn3 == 3'b001 && fn7 != 7'b0000000) c.illegal = 1'b1;
        if (fn3 == 3'b101) begin
          if (fn7 == 7'b0100000) c.alu_ctrl = ALU_SRA;
          else if (fn7 != 7'b0000000) c.illegal = 1'b1;
        end
      end
      OP_NIMM: begin
        c.reg_write = LW;
        c.reg_read  = 2'b11;
        c.imm_type  = RTYPE;
        if (fn7 == 7'b0000000) begin
          c.alu_ctrl = alu_fn3;
        end else if (fn7 == 7'b0100000) begin
          if (fn3 == 3'b000) c.alu_ctrl = ALU_SUB;
          else if (fn3 == 3'b101) c.alu_ctrl = ALU_SRA;
          else c.illegal = 1'b1;
        end else if (fn7 == 7'b0000001 && ENABLE_M != 0) begin
          c.mul_div    = 1'b1;
          c.mul_div_op = fn3;
        end else begin
          c.illegal = 1'b1;
        end
      end
      default: c.illegal = 1'b1;
    endcase
    // An illegal word must not write state or redirect; present it as a flagged bubble.
    if (c.illegal) begin
      c         = '0;
      c.illegal = 1'b1;
    end
    return c;
  endfunction

  logic [E_W-1:0]   head_dat;
  logic [CNT_W-1:0] fifo_cnt;
  logic             in_xfer, slot_free, fifo_nonempty, load_fifo, load_bypass, push, pop;
  logic [E_W-1:0]   load_dat;

  logic             out_valid_q, out_valid_d;
  logic [PC_W-1:0]  out_pc_q, out_pc_d;
  logic [31:0]      out_instr_q, out_instr_d;
  ctrl_t            ctrl_q, ctrl_d, ctrl_out;

  assign fifo_nonempty = (fifo_cnt != '0);
  assign in_ready      = (fifo_cnt < CNT_W'(DEPTH));
  assign in_xfer       = in_valid && in_ready;
  assign slot_free     = !out_valid_q || out_ready;
  // The FIFO head always wins the slot so older instructions never get overtaken.
  assign load_fifo     = slot_free && fifo_nonempty;
  assign load_bypass   = slot_free && !fifo_nonempty && in_xfer;
  assign push          = in_xfer && !load_bypass && !flush;
  assign pop           = load_fifo && !flush;
  assign load_dat      = fifo_nonempty ? head_dat : {in_pc, in_instr};

  decode_queue_fifo #(
    .W     (E_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdat_i  ({in_pc, in_instr}),
    .rdat_o  (head_dat),
    .count_o (fifo_cnt)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    ctrl_d      = ctrl_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_fifo || load_bypass) begin
      out_valid_d = 1'b1;
      out_pc_d    = load_dat[E_W-1:32];
      out_instr_d = load_dat[31:0];
      ctrl_d      = decode(load_dat[31:0]);
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      ctrl_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // Bubbles present an all-zero bundle so the ID/EX register never sees stale controls.
  assign ctrl_out    = out_valid_q ? ctrl_q : '0;

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign count       = fifo_cnt;
  assign JalD        = ctrl_out.jal;
  assign JalrD       = ctrl_out.jalr;
  assign LoadNpcD    = ctrl_out.load_npc;
  assign MemToRegD   = ctrl_out.mem_to_reg;
  assign AluSrc1D    = ctrl_out.alu_src1;
  assign RegWriteD   = ctrl_out.reg_write;
  assign MemWriteD   = ctrl_out.mem_write;
  assign RegReadD    = ctrl_out.reg_read;
  assign BranchTypeD = ctrl_out.branch_type;
  assign AluContrlD  = ctrl_out.alu_ctrl;
  assign AluSrc2D    = ctrl_out.alu_src2;
  assign ImmType     = ctrl_out.imm_type;
  assign MulDivD     = ctrl_out.mul_div;
  assign MulDivOpD   = ctrl_out.mul_div_op;
  assign IllegalD    = ctrl_out.illegal;
endmodule

// File: tb/tb_decode_queue_unit.sv
// tb_decode_queue_unit: scenario tasks with inline checks plus a pc/instr ordering scoreboard.
// Latency: checks sample 1 time unit after each rising edge; scoreboard samples on falling edges.
// Backpressure: out_ready is driven per scenario to exercise fill, drain, stream and flush.

module tb_decode_queue_unit;
  localparam logic [2:0] NOBRANCH = 3'd0, BGE = 3'd5;
  localparam logic [2:0] ITYPE = 3'd1, STYPE = 3'd2, UTYPE = 3'd4;
  localparam logic [2:0] NOREGWRITE = 3'd0, LW = 3'd3;
  localparam logic [3:0] ALU_SUB = 4'd4, ALU_ADD = 4'd3, ALU_LUI = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_instr = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_instr;
  logic        JalD, JalrD, LoadNpcD, MemToRegD, AluSrc1D, MulDivD, IllegalD;
  logic [2:0]  RegWriteD, BranchTypeD, ImmType, MulDivOpD, count;
  logic [3:0]  MemWriteD, AluContrlD;
  logic [1:0]  RegReadD, AluSrc2D;

  logic        m0_in_ready, m0_out_valid;
  logic [31:0] m0_out_pc, m0_out_instr;
  logic        m0_JalD, m0_JalrD, m0_LoadNpcD, m0_MemToRegD, m0_AluSrc1D, m0_MulDivD, m0_IllegalD;
  logic [2:0]  m0_RegWriteD, m0_BranchTypeD, m0_ImmType, m0_MulDivOpD, m0_count;
  logic [3:0]  m0_MemWriteD, m0_AluContrlD;
  logic [1:0]  m0_RegReadD, m0_AluSrc2D;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb_q [$];
  logic [63:0] sb_exp;
  logic [31:0] pc_r = 32'h0000_1000;

  always #5 clk = ~clk;

  decode_queue_unit #(.PC_W(32), .DEPTH(4), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .JalD(JalD), .JalrD(JalrD), .LoadNpcD(LoadNpcD),
    .MemToRegD(MemToRegD), .AluSrc1D(AluSrc1D), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .RegReadD(RegReadD), .BranchTypeD(BranchTypeD), .AluContrlD(AluContrlD), .AluSrc2D(AluSrc2D),
    .ImmType(ImmType), .MulDivD(MulDivD), .MulDivOpD(MulDivOpD), .IllegalD(IllegalD), .count(count)
  );

  decode_queue_unit #(.PC_W(32), .DEPTH(4), .ENABLE_M(0)) dut_m0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(m0_out_valid), .out_ready(out_ready),
    .out_pc(m0_out_pc), .out_instr(m0_out_instr), .JalD(m0_JalD), .JalrD(m0_JalrD),
    .LoadNpcD(m0_LoadNpcD), .MemToRegD(m0_MemToRegD), .AluSrc1D(m0_AluSrc1D),
    .RegWriteD(m0_RegWriteD), .MemWriteD(m0_MemWriteD), .RegReadD(m0_RegReadD),
    .BranchTypeD(m0_BranchTypeD), .AluContrlD(m0_AluContrlD), .AluSrc2D(m0_AluSrc2D),
    .ImmType(m0_ImmType), .MulDivD(m0_MulDivD), .MulDivOpD(m0_MulDivOpD), .IllegalD(m0_IllegalD),
    .count(m0_count)
  );

  // Ordering scoreboard: accepted words are queued, every output transfer must match the oldest one.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", out_pc, out_instr);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({out_pc, out_instr} !== sb_exp)
            $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                     out_pc, out_instr, sb_exp[63:32], sb_exp[31:0]);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_pc, in_instr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_one(input logic [31:0] ins);
    in_valid = 1'b1;
    pc_r     = pc_r + 32'd4;
    in_pc    = pc_r;
    in_instr = ins;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL rst_count: got %0d, required 0", count); else n_pass++;
    n_checks++; if ({out_pc, out_instr} !== 64'd0) $display("FAIL rst_pc_instr: got %h/%h, required 0/0", out_pc, out_instr); else n_pass++;
    n_checks++; if ({RegWriteD, BranchTypeD, MemWriteD, IllegalD, JalD} !== 12'd0)
      $display("FAIL rst_ctrl: got rw=%0d br=%0d mw=%b ill=%b, required all 0", RegWriteD, BranchTypeD, MemWriteD, IllegalD);
    else n_pass++;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", in_ready); else n_pass++;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h0;
    in_instr  = 32'h0050_0093;
    step();
    in_valid  = 1'b0;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b, required 1", out_valid); else n_pass++;
    n_checks++; if ({RegWriteD, AluSrc2D, ImmType, RegReadD, IllegalD} !== {LW, 2'b10, ITYPE, 2'b10, 1'b0})
      $display("FAIL addi_ctrl: got rw=%0d src2=%b imm=%0d rr=%b ill=%b, required rw=3 src2=10 imm=1 rr=10 ill=0",
               RegWriteD, AluSrc2D, ImmType, RegReadD, IllegalD);
    else n_pass++;
    n_checks++; if (count !== 3'd0) $display("FAIL addi_count: got %0d, required 0", count); else n_pass++;
    step();
    n_checks++; if ({out_valid, RegWriteD, ImmType} !== 7'd0)
      $display("FAIL bubble_ctrl: got valid=%b rw=%0d imm=%0d, required 0", out_valid, RegWriteD, ImmType);
    else n_pass++;
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_pc    = 32'(k * 4);
      in_instr = 32'h0000_0013 | (32'(k) << 20);
      step();
    end
    n_checks++; if ({count, in_ready} !== {3'd4, 1'b0}) $display("FAIL fill_full: got count=%0d in_ready=%b, required 4/0", count, in_ready); else n_pass++;
    in_pc    = 32'd20;
    in_instr = 32'h0050_0013;
    step();
    step();
    n_checks++; if ({count, out_pc} !== {3'd4, 32'd0}) $display("FAIL fill_hold: got count=%0d pc=%h, required 4/0", count, out_pc); else n_pass++;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({out_valid, out_pc} !== {1'b1, 32'(k * 4)})
        $display("FAIL drain_pc: got valid=%b pc=%h, required 1/%h", out_valid, out_pc, k * 4);
      else n_pass++;
      n_checks++; if (count !== 3'(4 - k)) $display("FAIL drain_count: got %0d, required %0d", count, 4 - k); else n_pass++;
      step();
    end
    n_checks++; if (out_valid !== 1'b0 || sb_q.size() != 0)
      $display("FAIL drain_end: got valid=%b pending=%0d, required 0/0", out_valid, sb_q.size());
    else n_pass++;
  endtask

  task automatic test_alu_mul();
    out_ready = 1'b1;
    drive_one(32'h4020_8033);
    n_checks++; if ({AluContrlD, IllegalD, MulDivD} !== {ALU_SUB, 1'b0, 1'b0})
      $display("FAIL sub_alu: got alu=%0d ill=%b md=%b, required 4/0/0", AluContrlD, IllegalD, MulDivD);
    else n_pass++;
    drive_one(32'h0220_81B3);
    n_checks++; if ({MulDivD, MulDivOpD, RegWriteD, AluContrlD, IllegalD} !== {1'b1, 3'b000, LW, ALU_ADD, 1'b0})
      $display("FAIL mul_dec: got md=%b op=%b rw=%0d alu=%0d ill=%b, required 1/000/3/3/0",
               MulDivD, MulDivOpD, RegWriteD, AluContrlD, IllegalD);
    else n_pass++;
    n_checks++; if ({m0_IllegalD, m0_MulDivD, m0_RegWriteD} !== {1'b1, 1'b0, NOREGWRITE})
      $display("FAIL mul_nom: got ill=%b md=%b rw=%0d, required 1/0/0", m0_IllegalD, m0_MulDivD, m0_RegWriteD);
    else n_pass++;
    step();
  endtask

  task automatic test_mem_branch();
    out_ready = 1'b1;
    drive_one(32'h0020_A023);
    n_checks++; if ({MemWriteD, RegReadD, ImmType, RegWriteD} !== {4'b1111, 2'b11, STYPE, NOREGWRITE})
      $display("FAIL sw_dec: got mw=%b rr=%b imm=%0d rw=%0d, required 1111/11/2/0", MemWriteD, RegReadD, ImmType, RegWriteD);
    else n_pass++;
    drive_one(32'h0020_D063);
    n_checks++; if ({BranchTypeD, AluSrc2D, RegWriteD} !== {BGE, 2'b00, NOREGWRITE})
      $display("FAIL bge_dec: got br=%0d src2=%b rw=%0d, required 5/00/0", BranchTypeD, AluSrc2D, RegWriteD);
    else n_pass++;
    drive_one(32'h1234_50B7);
    n_checks++; if ({AluContrlD, ImmType, RegWriteD, AluSrc1D} !== {ALU_LUI, UTYPE, LW, 1'b0})
      $display("FAIL lui_dec: got alu=%0d imm=%0d rw=%0d s1=%b, required 10/4/3/0", AluContrlD, ImmType, RegWriteD, AluSrc1D);
    else n_pass++;
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] bad [4];
    bad[0] = 32'h0000_307F;
    bad[1] = 32'h0000_3003;
    bad[2] = 32'h0000_B023;
    bad[3] = 32'h4010_9093;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_one(bad[i]);
      n_checks++; if ({out_valid, IllegalD, RegWriteD, MemWriteD, BranchTypeD} !== {1'b1, 1'b1, NOREGWRITE, 4'b0000, NOBRANCH})
        $display("FAIL illegal_%0d: got v=%b ill=%b rw=%0d mw=%b br=%0d, required 1/1/0/0000/0",
                 i, out_valid, IllegalD, RegWriteD, MemWriteD, BranchTypeD);
      else n_pass++;
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive_one(32'h0010_0013);
    n_checks++; if (count !== 3'd3) $display("FAIL flush_pre: got count=%0d, required 3", count); else n_pass++;
    in_valid = 1'b1;
    in_pc    = 32'h0000_0100;
    in_instr = 32'h0070_0013;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, count, in_ready} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL flush_state: got v=%b count=%0d rdy=%b, required 0/0/1", out_valid, count, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    step();
    step();
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_leak: got valid=%b pc=%h, required 0", out_valid, out_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive_one(32'h0000_0013 | (32'(k) << 20));
    n_checks++; if (count !== 3'd2) $display("FAIL b2b_pre: got count=%0d, required 2", count); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      pc_r     = pc_r + 32'd4;
      in_pc    = pc_r;
      in_instr = 32'h0000_0093 | (32'(i) << 20);
      step();
      n_checks++; if ({count, out_valid} !== {3'd2, 1'b1})
        $display("FAIL b2b_count_%0d: got count=%0d v=%b, required 2/1", i, count, out_valid);
      else n_pass++;
    end
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, count, out_pc, out_instr, RegWriteD, ImmType, RegReadD, AluSrc2D} !== 78'd0)
      $display("FAIL b2b_rst: got v=%b count=%0d pc=%h instr=%h rw=%0d, required all 0",
               out_valid, count, out_pc, out_instr, RegWriteD);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expired, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_fill_drain();
    test_alu_mul();
    test_mem_branch();
    test_illegal();
    test_flush();
    test_back_to_back();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
